// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: sleep/wake sequencer for one gated clock domain.
// It counts idle cycles, asks the domain to quiesce, gates the clock once
// the domain acknowledges, and ungates on activity. After ungating it waits
// a settle period before the domain is reported as ready.
// Optional feature macro: CLK_GATE_CTRL_STATS_EN adds a saturating count of
// gated cycles (o_gated_cycles) with a clear input (i_stats_clr).
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_busy,
  input  logic        i_wake,
  input  logic        i_force_on,
  input  logic        i_sleep_ack,
`ifdef CLK_GATE_CTRL_STATS_EN
  input  logic        i_stats_clr,
  output logic [31:0] o_gated_cycles,
`endif
  output logic        o_clk_en,
  output logic        o_sleep_req,
  output logic        o_ready,
  output logic        o_gated
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  // Terminal counter values; WAKE_LAST is unused when WAKE_CYCLES is 0
  // because GATED then goes straight back to RUN.
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1);
  localparam bit               SKIP_WAKE = (WAKE_CYCLES == 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, sleep_req_q, ready_q, gated_q;
  logic             activity;

  assign activity = i_busy | i_wake | i_force_on;

  // Next-state and shared idle/wake counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (activity) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Activity beats a same-cycle acknowledge: the domain has new work.
        if (activity) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (i_sleep_ack) begin
          state_d = ST_GATED;
          cnt_d   = '0;
        end
      end
      ST_GATED: begin
        if (activity) begin
          state_d = SKIP_WAKE ? ST_RUN : ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        // Settle period runs to completion regardless of inputs.
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with outputs registered from the next-state decode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      clk_en_q    <= 1'b1;
      sleep_req_q <= 1'b0;
      ready_q     <= 1'b1;
      gated_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= (state_d != ST_GATED);
      sleep_req_q <= (state_d == ST_DRAIN);
      ready_q     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      gated_q     <= (state_d == ST_GATED);
    end
  end

  assign o_clk_en    = clk_en_q;
  assign o_sleep_req = sleep_req_q;
  assign o_ready     = ready_q;
  assign o_gated     = gated_q;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [31:0] gated_cycles_q;

  // Saturating count of cycles spent with the clock gated; clear has priority.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_stats_clr) begin
      gated_cycles_q <= '0;
    end else if (gated_q && (gated_cycles_q != 32'hFFFF_FFFF)) begin
      gated_cycles_q <= gated_cycles_q + 32'd1;
    end
  end

  assign o_gated_cycles = gated_cycles_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl: two instances (default parameters, and a
// short-idle / no-settle variant) driven by the same stimulus and checked
// every cycle against a behavioural model of the sleep/wake rules.
module tb_clk_gate_ctrl;

  localparam int N = 2;
  localparam int P_IDLE [N] = '{16, 3};
  localparam int P_WAKE [N] = '{4, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, busy, wake, force_on, ack, stats_clr;
  logic clk_en_w [N];
  logic sleep_req_w [N];
  logic ready_w [N];
  logic gated_w [N];
  logic [31:0] gc_w [N];

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  // Behavioural model: "off" = clock gated, "req" = sleep requested,
  // settle = cycles still to wait before ready, idle = idle streak length.
  int          idle_m   [N];
  int          settle_m [N];
  bit          req_m    [N];
  bit          off_m    [N];
  logic [31:0] gc_m     [N];

  clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(4), .CNT_W(8)) u0 (
    .i_clk(clk), .i_rst(rst), .i_busy(busy), .i_wake(wake),
    .i_force_on(force_on), .i_sleep_ack(ack),
`ifdef CLK_GATE_CTRL_STATS_EN
    .i_stats_clr(stats_clr), .o_gated_cycles(gc_w[0]),
`endif
    .o_clk_en(clk_en_w[0]), .o_sleep_req(sleep_req_w[0]),
    .o_ready(ready_w[0]), .o_gated(gated_w[0])
  );

  clk_gate_ctrl #(.IDLE_CYCLES(3), .WAKE_CYCLES(0), .CNT_W(8)) u1 (
    .i_clk(clk), .i_rst(rst), .i_busy(busy), .i_wake(wake),
    .i_force_on(force_on), .i_sleep_ack(ack),
`ifdef CLK_GATE_CTRL_STATS_EN
    .i_stats_clr(stats_clr), .o_gated_cycles(gc_w[1]),
`endif
    .o_clk_en(clk_en_w[1]), .o_sleep_req(sleep_req_w[1]),
    .o_ready(ready_w[1]), .o_gated(gated_w[1])
  );

`ifndef CLK_GATE_CTRL_STATS_EN
  assign gc_w[0] = 32'd0;
  assign gc_w[1] = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs being presented.
  task automatic model_step();
    bit act;
    act = busy | wake | force_on;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        idle_m[i] = 0; settle_m[i] = 0; req_m[i] = 0; off_m[i] = 0; gc_m[i] = 0;
      end else begin
        if (stats_clr) gc_m[i] = 0;
        else if (off_m[i] && gc_m[i] != 32'hFFFF_FFFF) gc_m[i] = gc_m[i] + 1;

        if (off_m[i]) begin
          if (act) begin
            off_m[i] = 0; settle_m[i] = P_WAKE[i]; idle_m[i] = 0;
          end
        end else if (settle_m[i] > 0) begin
          settle_m[i] = settle_m[i] - 1; idle_m[i] = 0;
        end else if (req_m[i]) begin
          if (act) begin
            req_m[i] = 0; idle_m[i] = 0;
          end else if (ack) begin
            req_m[i] = 0; off_m[i] = 1;
          end
        end else begin
          idle_m[i] = act ? 0 : idle_m[i] + 1;
          if (idle_m[i] == P_IDLE[i]) begin
            req_m[i] = 1; idle_m[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.clk_en", i),    32'(clk_en_w[i]),    32'(!off_m[i]));
      chk($sformatf("u%0d.sleep_req", i), 32'(sleep_req_w[i]), 32'(req_m[i]));
      chk($sformatf("u%0d.ready", i),     32'(ready_w[i]),     32'(!off_m[i] && settle_m[i] == 0));
      chk($sformatf("u%0d.gated", i),     32'(gated_w[i]),     32'(off_m[i]));
`ifdef CLK_GATE_CTRL_STATS_EN
      chk($sformatf("u%0d.gated_cycles", i), gc_w[i], gc_m[i]);
`endif
    end
  endtask

  // One transaction = one clock edge: model update, then check at negedge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cycle++;
    check_all();
    $display("cyc %0d rst=%0b busy=%0b wake=%0b force=%0b ack=%0b | en=%0b%0b req=%0b%0b rdy=%0b%0b gated=%0b%0b",
             cycle, rst, busy, wake, force_on, ack, clk_en_w[0], clk_en_w[1],
             sleep_req_w[0], sleep_req_w[1], ready_w[0], ready_w[1], gated_w[0], gated_w[1]);
  endtask

  task automatic idle_inputs();
    rst = 0; busy = 0; wake = 0; force_on = 0; ack = 0; stats_clr = 0;
  endtask

  int pb;

  initial begin
    for (int i = 0; i < N; i++) begin
      idle_m[i] = 0; settle_m[i] = 0; req_m[i] = 0; off_m[i] = 0; gc_m[i] = 0;
    end
    idle_inputs();
    rst = 1;
    @(negedge clk);
    cyc(); cyc();
    chk("reset_clk_en", 32'(clk_en_w[0]), 32'd1);
    chk("reset_ready",  32'(ready_w[0]),  32'd1);
    chk("reset_req",    32'(sleep_req_w[0]), 32'd0);
    chk("reset_gated",  32'(gated_w[0]), 32'd0);

    // Idle from reset release: request after exactly 16 idle cycles.
    rst = 0;
    for (int k = 0; k < 15; k++) cyc();
    chk("idle15_no_req", 32'(sleep_req_w[0]), 32'd0);
    cyc();
    chk("idle16_req", 32'(sleep_req_w[0]), 32'd1);
    chk("idle16_clk_en", 32'(clk_en_w[0]), 32'd1);

    // Acknowledge: clock gates next cycle.
    ack = 1; cyc(); ack = 0;
    chk("ack_gated", 32'(gated_w[0]), 32'd1);
    chk("ack_clk_en", 32'(clk_en_w[0]), 32'd0);
    for (int k = 0; k < 5; k++) cyc();

    // Wake pulse: clock on immediately, ready after the settle period.
    wake = 1; cyc(); wake = 0;
    chk("wake_clk_en", 32'(clk_en_w[0]), 32'd1);
    chk("wake_ready_early", 32'(ready_w[0]), 32'd0);
    chk("wake0_ready", 32'(ready_w[1]), 32'd1);
    for (int k = 0; k < 3; k++) cyc();
    chk("wake_ready_t3", 32'(ready_w[0]), 32'd0);
    cyc();
    chk("wake_ready_t4", 32'(ready_w[0]), 32'd1);

    // Back to DRAIN, then busy and ack together: abort to RUN.
    for (int k = 0; k < 16; k++) cyc();
    chk("drain_again", 32'(sleep_req_w[0]), 32'd1);
    busy = 1; ack = 1; cyc(); busy = 0; ack = 0;
    chk("abort_req", 32'(sleep_req_w[0]), 32'd0);
    chk("abort_clk_en", 32'(clk_en_w[0]), 32'd1);
    for (int k = 0; k < 15; k++) cyc();
    chk("abort_idle15", 32'(sleep_req_w[0]), 32'd0);
    cyc();
    chk("abort_idle16", 32'(sleep_req_w[0]), 32'd1);

    // Busy pulses separated by 15 idle cycles never raise a request.
    busy = 1; cyc(); busy = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 15; k++) cyc();
      chk("gap15_no_req", 32'(sleep_req_w[0]), 32'd0);
      busy = 1; cyc(); busy = 0;
    end

    // Gate, then reset while gated.
    for (int k = 0; k < 16; k++) cyc();
    ack = 1; cyc(); ack = 0;
    for (int k = 0; k < 10; k++) cyc();
    chk("pre_rst_gated", 32'(gated_w[0]), 32'd1);
    stats_clr = 1; cyc(); stats_clr = 0;
    rst = 1; cyc(); rst = 0;
    chk("rst_gated_clk_en", 32'(clk_en_w[0]), 32'd1);
    chk("rst_gated_ready",  32'(ready_w[0]),  32'd1);
    chk("rst_gated_gated",  32'(gated_w[0]),  32'd0);

    // Randomized traffic with varying activity density.
    pb = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 256 == 0) begin
        case ($urandom_range(0, 3))
          0: pb = 0;
          1: pb = 1;
          2: pb = 5;
          default: pb = 40;
        endcase
      end
      rst       = ($urandom_range(0, 499) == 0);
      busy      = ($urandom_range(0, 99) < pb);
      wake      = ($urandom_range(0, 99) < 2);
      force_on  = ($urandom_range(0, 999) < 3);
      ack       = ($urandom_range(0, 99) < 25);
      stats_clr = ($urandom_range(0, 99) < 2);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
